// File: rtl/gpio_shift_out.sv
// Serialises GPIO output bytes MSB-first into a 74HC595-style shift/storage register.
// Define GPIO_SHIFT_OUT_FIFO_EN for a 4-entry byte FIFO; otherwise a single latest-wins holding register.
module gpio_shift_out #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] data_in,
  input  logic       data_update,
  output logic       sclk,
  output logic       sdo,
  output logic       latch,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned DW    = 8;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned BIT_W = 3;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DW-1:0]     shift_q, shift_d;
  logic              sclk_q, sclk_d;
  logic              sdo_q, sdo_d;
  logic              latch_q, latch_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;

  logic              pop;
  logic              buf_valid;
  logic              buf_valid_next;
  logic [DW-1:0]     buf_head;
  logic              buf_ovf;

  // The shifter only ever takes the head byte from IDLE, so a pop is IDLE with data pending.
  assign pop = (state_q == IDLE) && buf_valid;

`ifdef GPIO_SHIFT_OUT_FIFO_EN
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push;

  // A concurrent pop frees the slot, so a push into a full FIFO is still accepted then.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    push  = data_update && ((cnt_q != CNT_W'(DEPTH)) || pop);
    if (push) begin
      mem_d[wr_q] = data_in;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_d = rd_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign buf_valid      = (cnt_q != '0);
  assign buf_valid_next = (cnt_d != '0);
  assign buf_head       = mem_q[rd_q];
  assign buf_ovf        = data_update && !push;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
`else
  logic [DW-1:0] hold_q, hold_d;
  logic          valid_q, valid_d;

  // Latest update wins; overwriting an unconsumed byte is reported as overflow.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    buf_ovf = 1'b0;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (data_update) begin
      hold_d  = data_in;
      valid_d = 1'b1;
      buf_ovf = valid_q && !pop;
    end
  end

  assign buf_valid      = valid_q;
  assign buf_valid_next = valid_d;
  assign buf_head       = hold_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end
`endif

  // Next-state and registered output logic; each half-period lasts CLK_DIV cycles.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    sclk_d     = sclk_q;
    sdo_d      = sdo_q;
    latch_d    = latch_q;
    case (state_q)
      IDLE: begin
        if (buf_valid) begin
          state_d = SHIFT;
          shift_d = buf_head;
          bit_d   = '0;
          div_d   = '0;
          sclk_d  = 1'b0;
          sdo_d   = buf_head[DW-1];
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_W'(7)) begin
              state_d = LATCH;
              bit_d   = '0;
              latch_d = 1'b1;
            end else begin
              bit_d   = bit_q + BIT_W'(1);
              shift_d = {shift_q[DW-2:0], shift_q[DW-1]};
              sdo_d   = shift_q[DW-2];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          latch_d = 1'b0;
          state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sclk_d  = 1'b0;
        latch_d = 1'b0;
      end
    endcase
    busy_d     = (state_d != IDLE) || buf_valid_next;
    overflow_d = buf_ovf;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      latch_q    <= latch_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign sclk     = sclk_q;
  assign sdo      = sdo_q;
  assign latch    = latch_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_gpio_shift_out.sv
// Bench for gpio_shift_out: cycle-accurate vector table at CLK_DIV=4 plus byte-level sequences.
module tb_gpio_shift_out;

  typedef logic [7:0] bq_t[$];
  typedef int iq_t[$];

  typedef struct {
    int         gap;
    logic       n_rst;
    logic       upd;
    logic [7:0] din;
    logic       exp_sclk;
    logic       exp_sdo;
    logic       exp_latch;
    logic       exp_busy;
    logic       exp_ovf;
    logic       chk_sdo;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst, upd, sclk, sdo, latch, busy, ovf;
  logic [7:0] din;
  logic       n_rst1, upd1, sclk1, sdo1, latch1, busy1, ovf1;
  logic [7:0] din1;

  gpio_shift_out #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .data_in(din), .data_update(upd),
    .sclk(sclk), .sdo(sdo), .latch(latch), .busy(busy), .overflow(ovf)
  );

  gpio_shift_out #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst1), .data_in(din1), .data_update(upd1),
    .sclk(sclk1), .sdo(sdo1), .latch(latch1), .busy(busy1), .overflow(ovf1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Byte capture from the serial pins of the CLK_DIV=4 instance
  bq_t got;
  iq_t got_bits;
  int ovf_cnt = 0;
  int latch_hi = 0;
  logic [7:0] m_cap = '0;
  int m_bits = 0;
  logic m_ps = 1'b0, m_pl = 1'b0;
  always @(negedge clk) begin
    if (!n_rst) begin
      m_bits = 0; m_ps = 1'b0; m_pl = 1'b0;
    end else begin
      if (sclk && !m_ps) begin m_cap = {m_cap[6:0], sdo}; m_bits++; end
      if (latch && !m_pl) begin got.push_back(m_cap); got_bits.push_back(m_bits); m_bits = 0; end
      if (ovf) ovf_cnt++;
      if (latch) latch_hi++;
      m_ps = sclk; m_pl = latch;
    end
  end

  // Same capture for the CLK_DIV=1 instance, with latch rise times
  bq_t got1;
  iq_t got1_bits;
  iq_t rise1;
  int ovf1_cnt = 0;
  logic [7:0] m1_cap = '0;
  int m1_bits = 0;
  logic m1_ps = 1'b0, m1_pl = 1'b0;
  always @(negedge clk) begin
    if (!n_rst1) begin
      m1_bits = 0; m1_ps = 1'b0; m1_pl = 1'b0;
    end else begin
      if (sclk1 && !m1_ps) begin m1_cap = {m1_cap[6:0], sdo1}; m1_bits++; end
      if (latch1 && !m1_pl) begin
        got1.push_back(m1_cap); got1_bits.push_back(m1_bits); rise1.push_back(cyc); m1_bits = 0;
      end
      if (ovf1) ovf1_cnt++;
      m1_ps = sclk1; m1_pl = latch1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    upd = 1'b1; din = b;
    tick();
    upd = 1'b0;
  endtask

  task automatic strobe1(input logic [7:0] b);
    upd1 = 1'b1; din1 = b;
    tick();
    upd1 = 1'b0;
  endtask

  task automatic wait_idle(input int sel, input int budget, input string name);
    int n;
    n = 0;
    while (((sel == 0) ? busy : busy1) && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(n < budget), 32'd1);
  endtask

  task automatic cmp_bytes(input string name, input bq_t act, input iq_t bits, input bq_t exp_q);
    chk({name, "_count"}, 32'(act.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act.size()) begin
        chk($sformatf("%s_byte%0d", name, i), 32'(act[i]), 32'(exp_q[i]));
        chk($sformatf("%s_bits%0d", name, i), 32'(bits[i]), 32'd8);
      end
    end
  endtask

  task automatic clear_mon();
    got.delete(); got_bits.delete(); ovf_cnt = 0; latch_hi = 0;
    got1.delete(); got1_bits.delete(); rise1.delete(); ovf1_cnt = 0;
  endtask

  vec_t vec[16];
  bq_t  exp_q;
  int   bad;

  initial begin
    n_rst = 1'b0; upd = 1'b0; din = '0;
    n_rst1 = 1'b0; upd1 = 1'b0; din1 = '0;
    repeat (2) tick();
    n_rst1 = 1'b1;

    // Table: 0xA5 at CLK_DIV=4; gap = edges advanced before the check (inputs held for the first).
    vec[0]  = '{1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[1]  = '{1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[2]  = '{1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[3]  = '{3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[4]  = '{1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[5]  = '{4, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[6]  = '{8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[7]  = '{8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[8]  = '{8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[9]  = '{8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[10] = '{8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[11] = '{8, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[12] = '{7, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[13] = '{1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[14] = '{3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[15] = '{1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    clear_mon();
    for (int i = 0; i < 16; i++) begin
      n_rst = vec[i].n_rst; upd = vec[i].upd; din = vec[i].din;
      tick();
      upd = 1'b0; n_rst = 1'b1; din = '0;
      repeat (vec[i].gap - 1) tick();
      chk($sformatf("v%0d_sclk", i), 32'(sclk), 32'(vec[i].exp_sclk));
      if (vec[i].chk_sdo) chk($sformatf("v%0d_sdo", i), 32'(sdo), 32'(vec[i].exp_sdo));
      chk($sformatf("v%0d_latch", i), 32'(latch), 32'(vec[i].exp_latch));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vec[i].exp_busy));
      chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vec[i].exp_ovf));
    end
    exp_q = '{8'hA5};
    cmp_bytes("a5", got, got_bits, exp_q);
    chk("a5_latch_width", 32'(latch_hi), 32'd4);

    // Six strobes on consecutive cycles from idle
    clear_mon();
    for (int i = 0; i < 6; i++) strobe(8'(8'h10 + i));
    wait_idle(0, 2000, "burst6");
`ifdef GPIO_SHIFT_OUT_FIFO_EN
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    chk("burst6_ovf", 32'(ovf_cnt), 32'd1);
`else
    exp_q = '{8'h10, 8'h15};
    chk("burst6_ovf", 32'(ovf_cnt), 32'd4);
`endif
    cmp_bytes("burst6", got, got_bits, exp_q);

    // Push landing on the IDLE->SHIFT pop edge after the first byte
    clear_mon();
    for (int i = 0; i < 5; i++) strobe(8'(8'h21 + i));
    repeat (64) tick();
    chk("popedge_latch_hi", 32'(latch), 32'd1);
    tick();
    chk("popedge_idle_latch", 32'(latch), 32'd0);
    chk("popedge_idle_busy", 32'(busy), 32'd1);
    strobe(8'h26);
    wait_idle(0, 2000, "popedge");
`ifdef GPIO_SHIFT_OUT_FIFO_EN
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    chk("popedge_ovf", 32'(ovf_cnt), 32'd0);
`else
    exp_q = '{8'h21, 8'h25, 8'h26};
    chk("popedge_ovf", 32'(ovf_cnt), 32'd3);
`endif
    cmp_bytes("popedge", got, got_bits, exp_q);

    // Reset mid-byte (bit 3 of 0xFF) with a strobe presented during reset
    clear_mon();
    strobe(8'hFF);
    repeat (26) tick();
    n_rst = 1'b0; upd = 1'b1; din = 8'h99;
    tick();
    n_rst = 1'b1; upd = 1'b0; din = '0;
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_latch", 32'(latch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_busy_after", 32'(busy), 32'd0);
    chk("rst_no_latch", 32'(got.size()), 32'd0);
    clear_mon();
    strobe(8'h3C);
    wait_idle(0, 500, "post_rst");
    exp_q = '{8'h3C};
    cmp_bytes("post_rst", got, got_bits, exp_q);

    // Data toggling without a strobe must stay invisible
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      din = 8'($urandom);
      tick();
      if (sclk || latch || busy || ovf) bad++;
    end
    din = '0;
    chk("quiet_1000", 32'(bad), 32'd0);

    // CLK_DIV=1: two back-to-back strobes, one IDLE cycle between bytes
    clear_mon();
    strobe1(8'h01);
    strobe1(8'h80);
    wait_idle(1, 500, "div1");
    exp_q = '{8'h01, 8'h80};
    cmp_bytes("div1", got1, got1_bits, exp_q);
    chk("div1_ovf", 32'(ovf1_cnt), 32'd0);
    chk("div1_rises", 32'(rise1.size()), 32'd2);
    if (rise1.size() == 2) chk("div1_spacing", 32'(rise1[1] - rise1[0]), 32'd18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
